// File: rtl/pll_lock_supervisor_if.sv
// ============================================================================
// Module      : pll_lock_supervisor_if
// Description : PLL-side and fabric-side signals of the PLL lock supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       sys_reset_n;
    logic       pll_ok;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lost_count;

    // Master: the environment (PLL macro plus fabric control)
    modport master (
        output pll_locked, restart,
        input  pll_resetb, sys_reset_n, pll_ok, fail, retry_count, lost_count
    );

    // Slave: the supervisor itself
    modport slave (
        input  pll_locked, restart,
        output pll_resetb, sys_reset_n, pll_ok, fail, retry_count, lost_count
    );
endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Sequences PLL reset, qualifies lock, gates fabric reset and
//               retries/flags failure when the PLL will not lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pll_lock_supervisor #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 12000,
    parameter int MAX_RETRIES         = 4
) (
    input  wire logic             clock_in,
    input  wire logic             reset_n,
    pll_lock_supervisor_if.slave  pll
);

    localparam logic [2:0] c_PLL_RST   = 3'd0;
    localparam logic [2:0] c_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_STABLE    = 3'd2;
    localparam logic [2:0] c_RUN       = 3'd3;
    localparam logic [2:0] c_FAIL      = 3'd4;

    localparam logic [15:0] c_RST_LAST     = 16'(PLL_RESET_CYCLES - 1);
    localparam logic [15:0] c_STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_MAX_RETRIES  = 16'(MAX_RETRIES);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_sync1;
    logic        r_lock_s;
    logic        r_pll_resetb;
    logic        r_sys_reset_n;
    logic        r_pll_ok;
    logic        r_fail;
    logic [3:0]  r_retry;
    logic [7:0]  r_lost;

    assign pll.pll_resetb  = r_pll_resetb;
    assign pll.sys_reset_n = r_sys_reset_n;
    assign pll.pll_ok      = r_pll_ok;
    assign pll.fail        = r_fail;
    assign pll.retry_count = r_retry;
    assign pll.lost_count  = r_lost;

    // Outputs are registered alongside the state so every transition updates
    // them on the same edge, which keeps lock-loss latency at three edges.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_PLL_RST;
            r_cnt         <= 16'd0;
            r_sync1       <= 1'b0;
            r_lock_s      <= 1'b0;
            r_pll_resetb  <= 1'b0;
            r_sys_reset_n <= 1'b0;
            r_pll_ok      <= 1'b0;
            r_fail        <= 1'b0;
            r_retry       <= 4'd0;
            r_lost        <= 8'd0;
        end else begin
            r_sync1  <= pll.pll_locked;
            r_lock_s <= r_sync1;
            case (r_state)
                c_PLL_RST: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_state      <= c_WAIT_LOCK;
                        r_cnt        <= 16'd0;
                        r_pll_resetb <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout
                    if (r_lock_s) begin
                        r_state <= c_STABLE;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_cnt        <= 16'd0;
                        r_pll_resetb <= 1'b0;
                        if ({12'd0, r_retry} == c_MAX_RETRIES) begin
                            r_state <= c_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state <= c_PLL_RST;
                            r_retry <= r_retry + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_STABLE: begin
                    if (!r_lock_s) begin
                        r_state <= c_WAIT_LOCK;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        r_state       <= c_RUN;
                        r_cnt         <= 16'd0;
                        r_sys_reset_n <= 1'b1;
                        r_pll_ok      <= 1'b1;
                        r_retry       <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_RUN: begin
                    if (!r_lock_s) begin
                        r_state       <= c_PLL_RST;
                        r_cnt         <= 16'd0;
                        r_sys_reset_n <= 1'b0;
                        r_pll_ok      <= 1'b0;
                        r_pll_resetb  <= 1'b0;
                        if (r_lost != 8'hFF) begin
                            r_lost <= r_lost + 8'd1;
                        end
                    end
                end
                c_FAIL: begin
                    if (pll.restart) begin
                        r_state <= c_PLL_RST;
                        r_cnt   <= 16'd0;
                        r_retry <= 4'd0;
                        r_fail  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= c_PLL_RST;
                    r_cnt         <= 16'd0;
                    r_pll_resetb  <= 1'b0;
                    r_sys_reset_n <= 1'b0;
                    r_pll_ok      <= 1'b0;
                    r_fail        <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for pll_lock_supervisor (vector table,
//               directed corner sequences, randomized lock waveform).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_STAB = 8;
    localparam int P_TO   = 32;
    localparam int P_MAX  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_lock_supervisor_if bus();

    pll_lock_supervisor #(
        .PLL_RESET_CYCLES    (P_RST),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .MAX_RETRIES         (P_MAX)
    ) dut (
        .clock_in (clk),
        .reset_n  (rst_n),
        .pll      (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase of the power-up story plus time spent in it
    typedef enum int {M_RESET_PLL, M_ACQUIRE, M_QUALIFY, M_RUNNING, M_FAILED} phase_t;
    phase_t m_phase;
    int     m_age, m_attempts, m_losses;
    bit     m_s1, m_ls;

    function automatic void model_reset();
        m_phase = M_RESET_PLL; m_age = 0; m_attempts = 0; m_losses = 0;
        m_s1 = 1'b0; m_ls = 1'b0;
    endfunction

    function automatic void model_step(bit locked, bit req);
        bit seen;
        seen = m_ls;
        case (m_phase)
            M_RESET_PLL: begin
                m_age++;
                if (m_age == P_RST) begin m_phase = M_ACQUIRE; m_age = 0; end
            end
            M_ACQUIRE: begin
                if (seen) begin
                    m_phase = M_QUALIFY; m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == P_TO) begin
                        m_age = 0;
                        if (m_attempts == P_MAX) m_phase = M_FAILED;
                        else begin m_attempts++; m_phase = M_RESET_PLL; end
                    end
                end
            end
            M_QUALIFY: begin
                if (!seen) begin
                    m_phase = M_ACQUIRE; m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == P_STAB) begin m_phase = M_RUNNING; m_attempts = 0; end
                end
            end
            M_RUNNING: begin
                if (!seen) begin
                    if (m_losses < 255) m_losses++;
                    m_phase = M_RESET_PLL; m_age = 0;
                end
            end
            M_FAILED: begin
                if (req) begin m_attempts = 0; m_phase = M_RESET_PLL; m_age = 0; end
            end
            default: ;
        endcase
        m_ls = m_s1;
        m_s1 = locked;
    endfunction

    function automatic logic [15:0] model_out();
        logic [15:0] o;
        o[15]   = (m_phase == M_ACQUIRE) || (m_phase == M_QUALIFY) || (m_phase == M_RUNNING);
        o[14]   = (m_phase == M_RUNNING);
        o[13]   = (m_phase == M_RUNNING);
        o[12]   = (m_phase == M_FAILED);
        o[11:8] = m_attempts[3:0];
        o[7:0]  = m_losses[7:0];
        return o;
    endfunction

    function automatic logic [15:0] dut_out();
        return {bus.pll_resetb, bus.sys_reset_n, bus.pll_ok, bus.fail,
                bus.retry_count, bus.lost_count};
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare against the model
    task automatic cycle(bit locked, bit req);
        bus.pll_locked = locked;
        bus.restart    = req;
        @(posedge clk);
        model_step(locked, req);
        #1;
        check("model", dut_out(), model_out());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_out(), 16'h0000);
        rst_n = 1'b1;
    endtask

    task automatic wait_run(string name, int budget);
        for (int k = 0; k < budget && !bus.pll_ok; k++) cycle(1'b1, 1'b0);
        check(name, {15'd0, bus.pll_ok}, 16'd1);
    endtask

    typedef struct {
        bit          locked;
        bit          restart;
        int          n;
        logic [15:0] exp;   // {pll_resetb, sys_reset_n, pll_ok, fail, retry[3:0], lost[7:0]}
        string       name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;

        // Nominal bring-up, restart ignored in RUN, first lock loss
        vecs[0]  = '{1'b0, 1'b0, 3,  16'h0000, "pll_rst_low"};
        vecs[1]  = '{1'b0, 1'b0, 1,  16'h8000, "pll_rst_4cyc"};
        vecs[2]  = '{1'b0, 1'b0, 6,  16'h8000, "wait_lock"};
        vecs[3]  = '{1'b1, 1'b0, 10, 16'h8000, "pre_release"};
        vecs[4]  = '{1'b1, 1'b0, 1,  16'hE000, "release"};
        vecs[5]  = '{1'b1, 1'b0, 5,  16'hE000, "run_hold"};
        vecs[6]  = '{1'b1, 1'b1, 1,  16'hE000, "restart_in_run"};
        vecs[7]  = '{1'b0, 1'b0, 2,  16'hE000, "loss_sync_delay"};
        vecs[8]  = '{1'b0, 1'b0, 1,  16'h0001, "loss_3rd_edge"};
        vecs[9]  = '{1'b0, 1'b0, 3,  16'h0001, "re_reset_low"};
        vecs[10] = '{1'b0, 1'b0, 1,  16'h8001, "re_reset_end"};

        do_reset();
        for (int v = 0; v < 11; v++) begin
            for (int c = 0; c < vecs[v].n; c++) cycle(vecs[v].locked, vecs[v].restart);
            check(vecs[v].name, dut_out(), vecs[v].exp);
        end

        // Lock glitch while qualifying must not release fabric reset
        do_reset();
        repeat (10) cycle(1'b1, 1'b0);
        repeat (2)  cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("glitch_wait_lock", dut_out(), 16'h8000);
        repeat (9)  cycle(1'b1, 1'b0);
        check("glitch_no_release", {15'd0, bus.sys_reset_n}, 16'd0);
        cycle(1'b1, 1'b0);
        check("glitch_release", dut_out(), 16'hE000);

        // Three timed-out attempts, then FAIL until restart
        do_reset();
        repeat (36) cycle(1'b0, 1'b0);
        check("timeout_1", dut_out(), 16'h0100);
        repeat (71) cycle(1'b0, 1'b0);
        check("timeout_pre_fail", dut_out(), 16'h8200);
        cycle(1'b0, 1'b0);
        check("fail_enter", dut_out(), 16'h1200);
        repeat (20) cycle(1'b0, 1'b0);
        check("fail_hold", dut_out(), 16'h1200);
        cycle(1'b0, 1'b1);
        check("restart", dut_out(), 16'h0000);
        repeat (4) cycle(1'b0, 1'b0);
        check("restart_pll_rst", dut_out(), 16'h8000);

        // Lock arriving exactly on the timeout cycle takes the lock path
        do_reset();
        repeat (33) cycle(1'b0, 1'b0);
        repeat (3)  cycle(1'b1, 1'b0);
        check("lock_priority", dut_out(), 16'h8000);
        wait_run("prio_run", 20);

        // lost_count saturation
        for (int i = 0; i < 256; i++) begin
            repeat (3) cycle(1'b0, 1'b0);
            wait_run("sat_run", 40);
        end
        check("lost_sat", {8'd0, bus.lost_count}, 16'd255);

        // Asynchronous reset between edges while in RUN
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out(), 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized lock waveform with sporadic restart pulses
        do_reset();
        for (int s = 0; s < 250; s++) begin
            int  len;
            bit  lvl;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 160))
                                              : int'($urandom_range(1, 14));
            for (int c = 0; c < len; c++)
                cycle(lvl, $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 The block SHALL have parameter PLL_RESET_CYCLES, default 16, giving the number of clock_in cycles pll_resetb is held low per PLL reset attempt.
REQ-002 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the consecutive synchronized-lock cycles required before release.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 12000, giving the cycles allowed for lock acquisition per attempt (1 ms at 12 MHz).
REQ-004 The block SHALL have parameter MAX_RETRIES, default 4, giving the retry attempts after the first before declaring failure.
REQ-005 clock_in  input  1  12 MHz reference clock, the same clock that feeds the PLL; the only clock.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 pll_locked  input  1  PLL LOCK output, asynchronous to clock_in.
REQ-008 restart  input  1  single-cycle request to leave FAIL and re-run the sequence.
REQ-009 pll_resetb  output  1  drives the PLL RESETB pin; low holds the PLL in reset.
REQ-010 sys_reset_n  output  1  active-low reset for fabric logic; downstream domains re-synchronize its release.
REQ-011 pll_ok  output  1  high only in RUN.
REQ-012 fail  output  1  high only in FAIL.
REQ-013 retry_count  output  4  attempts consumed since the last RUN entry or restart.
REQ-014 lost_count  output  8  lock-loss events seen in RUN, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lock_s is the second flop, and the FSM uses only lock_s.
REQ-016 All outputs SHALL be registered.
REQ-017 There SHALL be one 16-bit cycle counter; all parameters SHALL be in the range 1..65535.
REQ-018 FSM states SHALL be PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-019 PLL_RST: pll_resetb=0 for exactly PLL_RESET_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
REQ-020 WAIT_LOCK: pll_resetb=1; lock_s=1 goes to STABLE with the counter cleared.
REQ-021 WAIT_LOCK timeout: if the counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0, then: if retry_count==MAX_RETRIES go to FAIL, else increment retry_count and go to PLL_RST.
REQ-022 STABLE: lock_s=0 returns to WAIT_LOCK with the counter cleared, the timeout restarts, and retry_count is unchanged.
REQ-023 STABLE: after LOCK_STABLE_CYCLES consecutive cycles with lock_s=1, go to RUN.
REQ-024 Entering RUN SHALL clear retry_count; sys_reset_n=1 and pll_ok=1 only in RUN.
REQ-025 sys_reset_n SHALL be 0 in every state other than RUN.
REQ-026 RUN: lock_s=0 SHALL go to PLL_RST, increment lost_count (saturating at 255), and drive sys_reset_n=0, pll_resetb=0 and pll_ok=0 on the same edge.
REQ-027 Lock-loss latency: sys_reset_n SHALL be low no later than the 3rd rising clock_in edge after pll_locked falls.
REQ-028 FAIL: pll_resetb=0 and fail=1; the state is held until restart=1.
REQ-029 restart=1 in FAIL SHALL clear retry_count and the counter and go to PLL_RST.
REQ-030 restart SHALL be ignored in every state other than FAIL.
REQ-031 A lock_s glitch shorter than LOCK_STABLE_CYCLES SHALL never release sys_reset_n.
REQ-032 lock_s=1 on the same cycle as the WAIT_LOCK timeout SHALL take the lock path (lock has priority).

Reset
REQ-033 While reset_n=0, asynchronously: state=PLL_RST, counter=0, sync flops=0, pll_resetb=0, sys_reset_n=0, pll_ok=0, fail=0, retry_count=0, lost_count=0.
REQ-034 After reset_n rises, PLL_RST SHALL begin counting on the first clock_in edge.
REQ-035 Reset asserted mid-operation SHALL force the reset values of REQ-033 immediately.

Verification
Bench parameters: PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
REQ-036 Nominal: release reset, raise pll_locked 10 cycles later and hold it -> pll_resetb low for exactly 4 cycles; sys_reset_n and pll_ok rise after 8 stable lock_s cycles; retry_count=0.
REQ-037 Glitch: in STABLE, drop pll_locked for 2 cycles after 5 locked cycles -> no release; WAIT_LOCK re-entered; release 8 cycles after lock returns.
REQ-038 Timeout and fail: hold pll_locked=0 -> three 32-cycle attempts with retry_count 0,1,2, then fail=1 and pll_resetb=0 held; pulse restart -> retry_count=0 and PLL_RST re-entered.
REQ-039 Lock loss in RUN: drop pll_locked -> sys_reset_n=0 within 3 edges, lost_count=1, full sequence repeats; force 256 losses -> lost_count stays at 255.
REQ-040 Async reset in RUN: assert reset_n mid-cycle -> all outputs take their reset values without waiting for a clock_in edge.
REQ-041 Priority and ignore: lock_s rising on the timeout cycle goes to STABLE, not PLL_RST; restart pulsed in RUN has no effect.
